// File: rtl/hba_qtr_emu_pkg.sv
// Shared constants for the QTR reflectance-sensor emulator: register map,
// control bits, channel state encoding and the 10 us delay unit.
package hba_qtr_emu_pkg;

    localparam logic [1:0] REG_CTRL        = 2'd0;
    localparam logic [1:0] REG_DELAY0      = 2'd1;
    localparam logic [1:0] REG_DELAY1      = 2'd2;
    localparam logic [1:0] REG_CYCLE_COUNT = 2'd3;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_INTR_EN_BIT = 1;

    // 100_000 ticks per second gives a 10 us delay unit.
    localparam int TICK_DIVISOR = 100_000;

    localparam logic [7:0] DELAY_HOLD = 8'd255;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_CHARGE = 2'd1,
        CH_DECAY  = 2'd2,
        CH_HOLD   = 2'd3
    } chan_state_t;

    function automatic int tick_clocks(input int clk_frequency);
        return clk_frequency / TICK_DIVISOR;
    endfunction

endpackage

// File: rtl/hba_qtr_emu_if.sv
// HBA slave bus bundle for the QTR emulator.
interface hba_qtr_emu_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DBUS_WIDTH = 8
);
    logic                  hba_rnw;
    logic                  hba_select;
    logic [ADDR_WIDTH-1:0] hba_abus;
    logic [DBUS_WIDTH-1:0] hba_dbus;
    logic [DBUS_WIDTH-1:0] hba_dbus_slave;
    logic                  hba_xferack_slave;
    logic                  slave_interrupt;

    modport master (
        output hba_rnw, hba_select, hba_abus, hba_dbus,
        input  hba_dbus_slave, hba_xferack_slave, slave_interrupt
    );

    modport slave (
        input  hba_rnw, hba_select, hba_abus, hba_dbus,
        output hba_dbus_slave, hba_xferack_slave, slave_interrupt
    );
endinterface

// File: rtl/hba_qtr_emu_chan.sv
// One emulated QTR channel: charge while driven high, then decay for
// delay * TICK clocks after release (or hold forever for delay 255).
module qtr_emu_chan
    import hba_qtr_emu_pkg::*;
#(
    parameter int TICK = 600
) (
    input  logic       hba_clk,
    input  logic       hba_reset,
    input  logic       enable,
    input  logic       out_en,
    input  logic       out_sig,
    input  logic [7:0] delay,
    output logic       in_sig,
    output logic       expired,
    output logic       released
);
    localparam int PRESC_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK - 1);

    chan_state_t        state, state_nxt;
    logic [7:0]         count, count_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic               tick, recharge;

    assign tick     = (presc == PRESC_LAST);
    assign recharge = out_en && out_sig;

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state <= CH_IDLE;
            count <= '0;
            presc <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            presc <= presc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        presc_nxt = presc;
        if (!enable) begin
            state_nxt = CH_IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else if (recharge) begin
            state_nxt = CH_CHARGE;
            count_nxt = '0;
            presc_nxt = '0;
        end else begin
            case (state)
                CH_CHARGE: begin
                    // Delay is latched here, so later register writes cannot disturb a running decay.
                    if (out_en)                   state_nxt = CH_IDLE;
                    else if (delay == 8'd0)       state_nxt = CH_IDLE;
                    else if (delay == DELAY_HOLD) state_nxt = CH_HOLD;
                    else begin
                        state_nxt = CH_DECAY;
                        count_nxt = delay;
                        presc_nxt = '0;
                    end
                end
                CH_DECAY: begin
                    if (tick) begin
                        presc_nxt = '0;
                        count_nxt = count - 8'd1;
                        if (count == 8'd1) state_nxt = CH_IDLE;
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_sig   = (state != CH_IDLE);
        expired  = enable && !recharge && (state == CH_DECAY) && tick && (count == 8'd1);
        released = enable && (state == CH_CHARGE) && !out_en && (delay == 8'd0);
    end

endmodule

// File: rtl/hba_qtr_emu.sv
// HBA peripheral emulating a two-channel QTR reflectance sensor; holds the
// register file and bus decode, with the channel timing in qtr_emu_chan.
module hba_qtr_emu
    import hba_qtr_emu_pkg::*;
#(
    parameter int CLK_FREQUENCY     = 60_000_000,
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0
) (
    input  logic          hba_clk,
    input  logic          hba_reset,
    hba_qtr_emu_if.slave  hba,
    input  logic [1:0]    qtr_out_en,
    input  logic [1:0]    qtr_out_sig,
    output logic [1:0]    qtr_in_sig
);
    localparam int TICK = tick_clocks(CLK_FREQUENCY);

    logic       decode, served, ack, wr_en, intr_q;
    logic [1:0] reg_idx, ctrl, expired, released;
    logic [7:0] delay0, delay1, cycle_count, rd8;
    logic [DBUS_WIDTH-1:0] dbus_q;
    logic       unused_abus;

    assign decode  = hba.hba_select &&
                     (hba.hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
    assign reg_idx = hba.hba_abus[1:0];
    assign wr_en   = ack && decode && !hba.hba_rnw;
    assign unused_abus = &{1'b0, hba.hba_abus[REG_ADDR_WIDTH-1:2]};

    always_comb begin
        rd8 = 8'd0;
        case (reg_idx)
            REG_CTRL:   rd8 = {6'd0, ctrl};
            REG_DELAY0: rd8 = delay0;
            REG_DELAY1: rd8 = delay1;
            default:    rd8 = cycle_count;
        endcase
    end

    // One ack per select assertion; served stays set until select drops.
    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            ack    <= 1'b0;
            served <= 1'b0;
            dbus_q <= '0;
        end else begin
            ack    <= decode && !served;
            dbus_q <= (decode && !served && hba.hba_rnw) ? DBUS_WIDTH'(rd8) : '0;
            if (!hba.hba_select) served <= 1'b0;
            else if (decode)     served <= 1'b1;
        end
    end

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            ctrl        <= '0;
            delay0      <= '0;
            delay1      <= '0;
            cycle_count <= '0;
            intr_q      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_idx)
                    REG_CTRL: begin
                        ctrl[CTRL_ENABLE_BIT]  <= hba.hba_dbus[CTRL_ENABLE_BIT];
                        ctrl[CTRL_INTR_EN_BIT] <= hba.hba_dbus[CTRL_INTR_EN_BIT];
                    end
                    REG_DELAY0: delay0 <= hba.hba_dbus[7:0];
                    REG_DELAY1: delay1 <= hba.hba_dbus[7:0];
                    default: ;
                endcase
            end
            if (expired[0] || released[0]) cycle_count <= cycle_count + 8'd1;
            intr_q <= ctrl[CTRL_INTR_EN_BIT] && (|expired);
        end
    end

    assign hba.hba_dbus_slave    = dbus_q;
    assign hba.hba_xferack_slave = ack;
    assign hba.slave_interrupt   = intr_q;

    qtr_emu_chan #(.TICK(TICK)) u_chan0 (
        .hba_clk  (hba_clk),
        .hba_reset(hba_reset),
        .enable   (ctrl[CTRL_ENABLE_BIT]),
        .out_en   (qtr_out_en[0]),
        .out_sig  (qtr_out_sig[0]),
        .delay    (delay0),
        .in_sig   (qtr_in_sig[0]),
        .expired  (expired[0]),
        .released (released[0])
    );

    qtr_emu_chan #(.TICK(TICK)) u_chan1 (
        .hba_clk  (hba_clk),
        .hba_reset(hba_reset),
        .enable   (ctrl[CTRL_ENABLE_BIT]),
        .out_en   (qtr_out_en[1]),
        .out_sig  (qtr_out_sig[1]),
        .delay    (delay1),
        .in_sig   (qtr_in_sig[1]),
        .expired  (expired[1]),
        .released (released[1])
    );

endmodule
